// File: rtl/line_packer_pkg.sv
// line_packer_pkg: shared widths, FSM state encoding, descriptor layout and
// the size-field encoder used by line_packer and desc_fifo.
package line_packer_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned WORDS_PER_LINE = 16;
    localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int unsigned WCNT_W         = 4;
    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DESC_W         = 16;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Descriptor written into table A: size 0 encodes a full 16-word line.
    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] size;
        logic [7:0] line;
    } desc_t;

    // Word count (1..16) to 4-bit size field; 16 wraps to 0.
    function automatic logic [3:0] size_encode(input logic [4:0] nwords);
        return nwords[3:0];
    endfunction

endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: synchronous FIFO of committed line indices.
// Ports:
//   aclk, reset_p      clock, asynchronous active-high reset (empties FIFO)
//   push, push_data    write side; push is ignored while full
//   pop, pop_data      read side; pop_data shows the head, 0 when empty
//   full, empty        occupancy flags
module desc_fifo
    import line_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             aclk,
    input  logic             reset_p,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array is not reset; validity is tracked by count.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_packer.sv
// line_packer: packs a 16-bit word stream into 256-bit lines (up to 16
// words), writes each line to memory B and a descriptor to table A, and
// streams the committed line index to the reader. A line-credit counter,
// replenished by crd_return, stalls input when no free line is left.
// Optional macro LINE_PACKER_TIMEOUT_EN: force-close a partial line after
// TIMEOUT idle cycles.
// Ports:
//   aclk, reset_p                    clock, asynchronous active-high reset
//   in_tdata/tvalid/tready/tlast     input word stream
//   wr_b_addr/data/we                line memory write port
//   wr_a_addr/data/we                descriptor table write port
//   out_tdata/tvalid/tready          committed line index stream
//   crd_return                       one freed line per pulse
//   crd_cnt                          free-line credits
module line_packer
    import line_packer_pkg::*;
#(
    parameter int unsigned LINES   = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   aclk,
    input  logic                   reset_p,
    input  logic [WORD_W-1:0]      in_tdata,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    input  logic                   in_tlast,
    output logic [ADDR_W-1:0]      wr_b_addr,
    output logic [LINE_W-1:0]      wr_b_data,
    output logic                   wr_b_we,
    output logic [ADDR_W-1:0]      wr_a_addr,
    output logic [DESC_W-1:0]      wr_a_data,
    output logic                   wr_a_we,
    output logic [ADDR_W-1:0]      out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    input  logic                   crd_return,
    output logic [$clog2(LINES):0] crd_cnt
);

    localparam int unsigned PTR_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned CRD_W = $clog2(LINES) + 1;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(LINES);

    // Elaboration-time parameter legality.
    if (LINES < 2 || LINES > 256 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
        $error("line_packer: LINES must be a power of two in 2..256");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("line_packer: TIMEOUT must be non-zero");
    end

    state_t            state;
    logic [PTR_W-1:0]  line_ptr;
    logic [WCNT_W-1:0] wcnt;
    logic [LINE_W-1:0] acc;

    logic              accept_c;
    logic              close_c;
    logic              timeout_c;
    logic              commit_c;
    logic [LINE_W-1:0] acc_merge_c;
    logic [LINE_W-1:0] commit_data_c;
    logic [3:0]        commit_size_c;
    desc_t             commit_desc_c;
    logic [CRD_W-1:0]  crd_next_c;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    assign accept_c = in_tvalid & in_tready;
    assign close_c  = accept_c & (in_tlast | (wcnt == WCNT_W'(WORDS_PER_LINE - 1)));

`ifdef LINE_PACKER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle;

    // Fires on the TIMEOUT-th consecutive idle cycle of a non-empty line.
    assign timeout_c = (state == S_FILL) & ~accept_c & (wcnt != '0) &
                       (idle == IDLE_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    assign commit_c = close_c | timeout_c;

    // Accumulator with the incoming word dropped into slot wcnt.
    always_comb begin
        acc_merge_c = acc;
        acc_merge_c[wcnt * WORD_W +: WORD_W] = in_tdata;
    end

    // Line content and size for a word-closed or timeout-closed line.
    always_comb begin
        commit_data_c = acc_merge_c;
        commit_size_c = size_encode(5'(wcnt) + 5'd1);
        if (!accept_c) begin
            commit_data_c = acc;
            commit_size_c = size_encode(5'(wcnt));
        end
        commit_desc_c = '{pad: 4'h0, size: commit_size_c, line: ADDR_W'(line_ptr)};
    end

    // Credit update: commit consumes, return frees, both at once cancel.
    always_comb begin
        crd_next_c = crd_cnt;
        if ((state == S_COMMIT) && !crd_return) begin
            crd_next_c = crd_cnt - CRD_W'(1);
        end else if (crd_return && (state != S_COMMIT) && (crd_cnt != CRD_MAX)) begin
            crd_next_c = crd_cnt + CRD_W'(1);
        end
    end

    // Control FSM, accumulator and registered write ports.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            state     <= S_FILL;
            in_tready <= 1'b1;
            line_ptr  <= '0;
            wcnt      <= '0;
            acc       <= '0;
            crd_cnt   <= CRD_MAX;
            wr_b_we   <= 1'b0;
            wr_a_we   <= 1'b0;
            wr_b_addr <= '0;
            wr_a_addr <= '0;
            wr_b_data <= '0;
            wr_a_data <= '0;
`ifdef LINE_PACKER_TIMEOUT_EN
            idle      <= '0;
`endif
        end else begin
            wr_b_we <= 1'b0;
            wr_a_we <= 1'b0;
            crd_cnt <= crd_next_c;
            case (state)
                S_WAIT: begin
                    if (crd_cnt != '0) begin
                        state     <= S_FILL;
                        in_tready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept_c) begin
                        acc  <= acc_merge_c;
                        wcnt <= wcnt + WCNT_W'(1);
                    end
`ifdef LINE_PACKER_TIMEOUT_EN
                    if (accept_c || (wcnt == '0)) begin
                        idle <= '0;
                    end else begin
                        idle <= idle + IDLE_W'(1);
                    end
`endif
                    if (commit_c) begin
                        state     <= S_COMMIT;
                        in_tready <= 1'b0;
                        wr_b_we   <= 1'b1;
                        wr_a_we   <= 1'b1;
                        wr_b_addr <= ADDR_W'(line_ptr);
                        wr_a_addr <= ADDR_W'(line_ptr);
                        wr_b_data <= commit_data_c;
                        wr_a_data <= commit_desc_c;
                    end
                end
                S_COMMIT: begin
                    acc      <= '0;
                    wcnt     <= '0;
                    line_ptr <= line_ptr + PTR_W'(1);
`ifdef LINE_PACKER_TIMEOUT_EN
                    idle     <= '0;
`endif
                    if (crd_next_c != '0) begin
                        state     <= S_FILL;
                        in_tready <= 1'b1;
                    end else begin
                        state     <= S_WAIT;
                    end
                end
                default: begin
                    state     <= S_WAIT;
                    in_tready <= 1'b0;
                end
            endcase
        end
    end

    // Index of the line being committed; wr_a_addr still holds it here.
    assign fifo_push  = (state == S_COMMIT);
    assign out_tvalid = ~fifo_empty;

    desc_fifo #(
        .DEPTH (LINES),
        .WIDTH (ADDR_W)
    ) u_desc_fifo (
        .aclk      (aclk),
        .reset_p   (reset_p),
        .push      (fifo_push),
        .push_data (wr_a_addr),
        .pop       (out_tvalid & out_tready),
        .pop_data  (out_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outstanding descriptors are bounded by held lines, so this never fires.
    a_no_overflow: assert property (@(posedge aclk) disable iff (reset_p)
                                    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_line_packer.sv
// tb_line_packer: directed, table-driven bench for line_packer (LINES=256,
// TIMEOUT=8). Build with LINE_PACKER_TIMEOUT_EN to exercise the timeout.
module tb_line_packer;

    logic          aclk       = 1'b0;
    logic          reset_p    = 1'b1;
    logic [15:0]   in_tdata   = '0;
    logic          in_tvalid  = 1'b0;
    logic          in_tready;
    logic          in_tlast   = 1'b0;
    logic [7:0]    wr_b_addr;
    logic [255:0]  wr_b_data;
    logic          wr_b_we;
    logic [7:0]    wr_a_addr;
    logic [15:0]   wr_a_data;
    logic          wr_a_we;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          crd_return = 1'b0;
    logic [8:0]    crd_cnt;

    line_packer #(.LINES(256), .TIMEOUT(8)) dut (
        .aclk       (aclk),
        .reset_p    (reset_p),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .wr_b_addr  (wr_b_addr),
        .wr_b_data  (wr_b_data),
        .wr_b_we    (wr_b_we),
        .wr_a_addr  (wr_a_addr),
        .wr_a_data  (wr_a_data),
        .wr_a_we    (wr_a_we),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .crd_return (crd_return),
        .crd_cnt    (crd_cnt)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Write/pop logs collected mid-cycle.
    logic [7:0]   wq_addr[$];
    logic [15:0]  wq_adata[$];
    logic [255:0] wq_bdata[$];
    int           wq_cyc[$];
    logic [7:0]   pq[$];
    int           rise_cyc = -1;
    logic         prev_tv = 1'b0;
    int           port_mismatch = 0;

    always @(negedge aclk) begin
        if (wr_b_we) begin
            wq_addr.push_back(wr_b_addr);
            wq_adata.push_back(wr_a_data);
            wq_bdata.push_back(wr_b_data);
            wq_cyc.push_back(cyc);
        end
        if ((wr_b_we != wr_a_we) || (wr_b_we && (wr_b_addr != wr_a_addr)))
            port_mismatch++;
        if (out_tvalid && out_tready) pq.push_back(out_tdata);
        if (out_tvalid && !prev_tv) rise_cyc = cyc;
        prev_tv = out_tvalid;
    end

    typedef struct {
        int          nwords;
        logic [15:0] word0;
        logic        last;
        logic [7:0]  exp_addr;
        logic [15:0] exp_adata;
    } vec_t;
    vec_t vecs[6];

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack(input int n, input logic [15:0] w0);
        logic [255:0] r = '0;
        for (int k = 0; k < n; k++) r[16*k +: 16] = w0 + 16'(k);
        return r;
    endfunction

    task automatic clear_logs();
        wq_addr.delete(); wq_adata.delete(); wq_bdata.delete(); wq_cyc.delete();
        pq.delete();
        rise_cyc = -1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input int max_cyc,
                             output logic ok, output int acc_cyc);
        ok = 1'b0;
        acc_cyc = -1;
        in_tdata = d; in_tlast = last; in_tvalid = 1'b1;
        for (int g = 0; g < max_cyc && !ok; g++) begin
            @(negedge aclk);
            if (in_tready) begin ok = 1'b1; acc_cyc = cyc; end
        end
        @(posedge aclk); #1;
        in_tvalid = 1'b0; in_tlast = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [15:0] w0, input logic last, output int last_acc);
        logic ok;
        for (int k = 0; k < n; k++) begin
            send_word(w0 + 16'(k), last && (k == n - 1), 200, ok, last_acc);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout: word %0d not accepted within 200 cycles", k);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        reset_p = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0; crd_return = 1'b0;
        repeat (2) @(posedge aclk);
        #1 reset_p = 1'b0;
    endtask

    initial begin
        int   acc;
        int   acc_t[32];
        logic ok;
        int   bad;

        vecs[0] = '{16, 16'h0000, 1'b0, 8'h00, 16'h0000};
        vecs[1] = '{ 3, 16'h00A1, 1'b1, 8'h01, 16'h0301};
        vecs[2] = '{ 1, 16'h1234, 1'b1, 8'h02, 16'h0102};
        vecs[3] = '{15, 16'h8000, 1'b1, 8'h03, 16'h0F03};
        vecs[4] = '{16, 16'hFFF0, 1'b1, 8'h04, 16'h0004};
        vecs[5] = '{ 5, 16'h0100, 1'b1, 8'h05, 16'h0505};

        // Reset values, sampled while reset is held.
        repeat (2) @(posedge aclk);
        #1;
        check_int("rst_in_tready", int'(in_tready), 1);
        check_int("rst_wr_b_we", int'(wr_b_we), 0);
        check_int("rst_wr_a_we", int'(wr_a_we), 0);
        check_int("rst_out_tvalid", int'(out_tvalid), 0);
        check_int("rst_wr_b_addr", int'(wr_b_addr), 0);
        check_int("rst_wr_a_addr", int'(wr_a_addr), 0);
        check_int("rst_wr_a_data", int'(wr_a_data), 0);
        check_int("rst_out_tdata", int'(out_tdata), 0);
        check_int("rst_crd_cnt", int'(crd_cnt), 256);
        check_vec("rst_wr_b_data", wr_b_data, '0);
        reset_p = 1'b0;
        out_tready = 1'b1;

        // Table: one line per vector, write + descriptor + stream index + latency.
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            send_line(vecs[i].nwords, vecs[i].word0, vecs[i].last, acc);
            repeat (4) @(posedge aclk);
            #1;
            check_int($sformatf("v%0d_writes", i), wq_addr.size(), 1);
            if (wq_addr.size() > 0) begin
                check_int($sformatf("v%0d_addr", i), int'(wq_addr[0]), int'(vecs[i].exp_addr));
                check_int($sformatf("v%0d_adata", i), int'(wq_adata[0]), int'(vecs[i].exp_adata));
                check_vec($sformatf("v%0d_bdata", i), wq_bdata[0], pack(vecs[i].nwords, vecs[i].word0));
                check_int($sformatf("v%0d_we_cycle", i), wq_cyc[0], acc + 1);
            end
            check_int($sformatf("v%0d_pops", i), pq.size(), 1);
            if (pq.size() > 0)
                check_int($sformatf("v%0d_out_tdata", i), int'(pq[0]), int'(vecs[i].exp_addr));
            check_int($sformatf("v%0d_tvalid_rise", i), rise_cyc, acc + 2);
        end
        check_int("crd_after_table", int'(crd_cnt), 250);

        // Throughput: two full lines back to back, one bubble for the commit.
        clear_logs();
        for (int k = 0; k < 32; k++) begin
            send_word(16'(k), 1'b0, 200, ok, acc_t[k]);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL tput_accept_timeout: word %0d", k);
            end
        end
        repeat (4) @(posedge aclk);
        #1;
        check_int("tput_first_line", acc_t[15] - acc_t[0], 15);
        check_int("tput_line_gap", acc_t[16] - acc_t[0], 17);
        check_int("tput_second_line", acc_t[31] - acc_t[16], 15);
        check_int("tput_writes", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check_int("tput_addr0", int'(wq_addr[0]), 6);
            check_int("tput_addr1", int'(wq_addr[1]), 7);
        end

        // Reset mid-line: queued index dropped, partial line discarded.
        out_tready = 1'b0;
        clear_logs();
        send_line(1, 16'h5555, 1'b1, acc);
        repeat (3) @(posedge aclk);
        #1;
        check_int("held_out_tvalid", int'(out_tvalid), 1);
        send_line(5, 16'h0700, 1'b0, acc);
        do_reset();
        repeat (4) @(posedge aclk);
        #1;
        check_int("midrst_writes", wq_addr.size(), 1);
        check_int("midrst_crd_cnt", int'(crd_cnt), 256);
        check_int("midrst_out_tvalid", int'(out_tvalid), 0);
        out_tready = 1'b1;
        clear_logs();
        send_line(3, 16'h00A1, 1'b1, acc);
        send_line(1, 16'h0042, 1'b1, acc);
        repeat (4) @(posedge aclk);
        #1;
        check_int("postrst_writes", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check_int("postrst_addr0", int'(wq_addr[0]), 0);
            check_int("postrst_adata0", int'(wq_adata[0]), 16'h0300);
            check_vec("postrst_bdata0", wq_bdata[0], 256'h00A3_00A2_00A1);
            check_int("postrst_addr1", int'(wq_addr[1]), 1);
            check_int("postrst_adata1", int'(wq_adata[1]), 16'h0101);
        end

        // Credit exhaustion, then a single returned credit admits one line.
        do_reset();
        clear_logs();
        for (int i = 0; i < 256; i++) send_line(1, 16'(i), 1'b1, acc);
        repeat (4) @(posedge aclk);
        #1;
        check_int("exh_writes", wq_addr.size(), 256);
        if (wq_addr.size() == 256) check_int("exh_last_addr", int'(wq_addr[255]), 255);
        check_int("exh_crd_cnt", int'(crd_cnt), 0);
        check_int("exh_in_tready", int'(in_tready), 0);
        crd_return = 1'b1;
        @(posedge aclk); #1;
        crd_return = 1'b0;
        check_int("ret_crd_n1", int'(crd_cnt), 1);
        check_int("ret_tready_n1", int'(in_tready), 0);
        @(posedge aclk); #1;
        check_int("ret_tready_n2", int'(in_tready), 1);
        send_word(16'hBEEF, 1'b1, 20, ok, acc);
        check_int("ret_first_accepted", int'(ok), 1);
        send_word(16'hCAFE, 1'b1, 20, ok, acc);
        check_int("ret_second_blocked", int'(ok), 0);
        repeat (2) @(posedge aclk);
        #1;
        check_int("ret_writes", wq_addr.size(), 257);
        if (wq_addr.size() == 257) check_int("ret_wrap_addr", int'(wq_addr[256]), 0);

        // Commit coinciding with crd_return; 300 lines wrap the line pointer.
        do_reset();
        clear_logs();
        send_line(1, 16'h0001, 1'b1, acc);
        send_line(1, 16'h0002, 1'b1, acc);
        repeat (3) @(posedge aclk);
        #1;
        check_int("coin_pre_crd", int'(crd_cnt), 254);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            send_line(1, 16'(i), 1'b1, acc);
            crd_return = 1'b1;
            @(posedge aclk); #1;
            crd_return = 1'b0;
            if (i == 0) check_int("coin_first_crd", int'(crd_cnt), 254);
            if (int'(crd_cnt) != 254) bad++;
        end
        repeat (4) @(posedge aclk);
        #1;
        check_int("coin_crd_deviations", bad, 0);
        check_int("wrap_writes", wq_addr.size(), 302);
        check_int("wrap_pops", pq.size(), 302);
        if (wq_addr.size() == 302) begin
            bad = 0;
            for (int i = 0; i < 302; i++) if (int'(wq_addr[i]) != (i % 256)) bad++;
            check_int("wrap_addr_sequence", bad, 0);
            check_int("wrap_addr_255", int'(wq_addr[255]), 255);
            check_int("wrap_addr_256", int'(wq_addr[256]), 0);
            check_int("wrap_addr_last", int'(wq_addr[301]), 45);
        end

        // Idle partial line: force-closed only when the timeout is built in.
        do_reset();
        clear_logs();
        send_line(2, 16'h0B00, 1'b0, acc);
        repeat (30) @(posedge aclk);
        #1;
`ifdef LINE_PACKER_TIMEOUT_EN
        check_int("to_writes", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            check_int("to_we_cycle", wq_cyc[0], acc + 9);
            check_int("to_adata", int'(wq_adata[0]), 16'h0200);
            check_vec("to_bdata", wq_bdata[0], 256'h0B01_0B00);
        end
`else
        check_int("noto_writes", wq_addr.size(), 0);
        check_int("noto_in_tready", int'(in_tready), 1);
`endif

        check_int("port_a_b_agree", port_mismatch, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_packer.md
# line_packer

Write-side counterpart of the credit-return read path. Accepts a 16-bit AXI-stream of words, packs them into 256-bit lines of up to 16 words, writes each line into line memory B and a 16-bit descriptor into table A, and emits the line index on an 8-bit output stream for the reader. Flow is gated by a line-credit counter that the reader replenishes as it frees lines.

## Interface
- LINES, 256: lines in memory B and entries in table A; power of two, 2..256.
- TIMEOUT, 64: idle cycles before a partial line is force-closed; used only with the timeout macro.
- aclk  in  1  clock.
- reset_p  in  1  asynchronous, active-high reset.
- in_tdata  in  16  input word.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready.
- in_tlast  in  1  last word of the packet; closes the current line.
- wr_b_addr  out  8  line index.
- wr_b_data  out  256  packed line; word k at bits [16k+15:16k].
- wr_b_we  out  1  line write strobe.
- wr_a_addr  out  8  descriptor index; equal to wr_b_addr.
- wr_a_data  out  16  descriptor {4'h0, size[3:0], line[7:0]}; size 0 means 16 words.
- wr_a_we  out  1  descriptor write strobe.
- out_tdata  out  8  index of a committed descriptor.
- out_tvalid  out  1  valid.
- out_tready  in  1  ready.
- crd_return  in  1  single-cycle pulse; the reader has freed one line.
- crd_cnt  out  $clog2(LINES)+1  free-line credits, for status.

## Operation
- FSM states:
  - S_WAIT: in_tready=0.
  - S_FILL: in_tready=1.
  - S_COMMIT: in_tready=0; exactly one cycle.
- FSM transitions:
  - S_WAIT → S_FILL when crd_cnt≠0.
  - S_FILL → S_COMMIT on an accepted word that is the 16th word or carries tlast.
  - S_COMMIT → S_FILL if the post-update crd_cnt≠0, else → S_WAIT.
- Accumulator and word count:
  - Each accepted word is written into the accumulator slot wcnt.
  - wcnt is 4 bits and increments modulo 16.
  - Size field = number of words in the line, modulo 16 (16 encodes as 0).
- In S_COMMIT:
  - wr_b_we=wr_a_we=1, both at addr line_ptr.
  - Unused slots of wr_b_data are zero.
  - The index is pushed into the descriptor FIFO.
  - line_ptr increments modulo LINES.
  - The accumulator and wcnt clear.
- Credits:
  - The commit decrements crd_cnt.
  - crd_return increments crd_cnt.
  - A commit and a crd_return in the same cycle leave crd_cnt unchanged.
  - A crd_return while crd_cnt==LINES is ignored; the counter saturates.
- Descriptor FIFO depth is LINES. It cannot overflow because outstanding descriptors never exceed held lines, which never exceed LINES; a push while full is an assertion failure.
- Output stream: out_tvalid = FIFO not empty; a pop occurs on out_tvalid & out_tready.
- Reset (also mid-operation):
  - State goes to S_FILL with crd_cnt=LINES.
  - line_ptr=0, wcnt=0, accumulator=0.
  - The FIFO empties.
  - Any partial line is discarded.

## Timing
- Reset values: in_tready=1, wr_b_we=wr_a_we=0, out_tvalid=0, all address/data outputs 0, crd_cnt=LINES.
- A closing word accepted in cycle N:
  - Write strobes are high in cycle N+1.
  - out_tvalid rises in N+2 (if the FIFO was empty).
- All write-port outputs are registered. Strobes are single-cycle.
- Sustained throughput is 16 words per 17 cycles.
- A crd_return in cycle N is reflected in crd_cnt in N+1. From S_WAIT, in_tready rises in N+2.

## Configuration
- LINE_PACKER_TIMEOUT_EN defined:
  - In S_FILL with wcnt≠0, an idle counter increments on every cycle without an accepted word and clears on an accepted word.
  - On reaching TIMEOUT it forces S_COMMIT with the current size.
- LINE_PACKER_TIMEOUT_EN undefined: lines close only on the 16th word or tlast, and the idle counter is absent.

## Structure
- Package line_packer_pkg holds:
  - state enum (S_WAIT, S_FILL, S_COMMIT)
  - WORD_W=16, WORDS_PER_LINE=16, LINE_W=256
  - descriptor struct {pad, size, line}
  - size-encode function
- Sub-module desc_fifo: synchronous FIFO, 8 bits wide, DEPTH=LINES, with full/empty flags and the same reset_p.

## Test plan
- 16 words 0x0000..0x000F, no tlast: one B write at addr 0 with word k=k; A data 0x0000; out_tdata=0 two cycles later.
- 3 words 0xA1,0xA2,0xA3 with tlast on the third: B bits[47:0]=A3A2A1, remaining bits 0; A data 0x0300 at addr 0; next line uses addr 1.
- LINES=4, out_tready=1, no crd_return: after 4 lines, in_tready=0 in S_WAIT. One crd_return pulse → in_tready=1 two cycles later and exactly one more line is accepted.
- Commit coinciding with crd_return: crd_cnt unchanged. 300 back-to-back lines with returns: line_ptr wraps 255→0.
- reset_p asserted mid-line after 5 words: no writes issued; crd_cnt=LINES; FIFO empty; the next line starts at addr 0.
- With LINE_PACKER_TIMEOUT_EN and TIMEOUT=8: 2 words, then idle → commit with size 2 exactly 8 idle cycles after the last word; without the macro, no commit occurs.
